// File: rtl/flags_cond_unit.sv
// rtl/flags_cond_unit.sv - condition-code register with same-cycle bypass and branch condition evaluator
module flags_cond_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] alu_flags,
    input  logic       ex_valid,
    input  logic       s_bit,
    input  logic [3:0] cond,
    input  logic       cond_req,
    input  logic       stall,
    input  logic       flush,
    output logic [3:0] psr_flags,
    output logic       carry_in,
    output logic       cond_true,
    output logic       cond_valid
);

    logic [3:0] psr_q, psr_d;
    logic       cond_true_q, cond_true_d;
    logic       cond_valid_q, cond_valid_d;
    logic [3:0] eff_flags;
    logic       wr_cc;
    logic       psr_upd;
    logic       eval_res;
    logic       z_f, n_f, c_f, v_f;

    // EX flag writer forwards to ID even while stalled; only the PSR write waits.
    assign wr_cc     = ex_valid & s_bit & ~flush;
    assign psr_upd   = wr_cc & ~stall;
    assign eff_flags = wr_cc ? alu_flags : psr_q;

    assign z_f = eff_flags[3];
    assign n_f = eff_flags[2];
    assign c_f = eff_flags[1];
    assign v_f = eff_flags[0];

    always_comb begin
        eval_res = 1'b0;
        case (cond)
            4'd0:  eval_res = 1'b0;
            4'd1:  eval_res = z_f;
            4'd2:  eval_res = z_f | (n_f ^ v_f);
            4'd3:  eval_res = n_f ^ v_f;
            4'd4:  eval_res = c_f | z_f;
            4'd5:  eval_res = c_f;
            4'd6:  eval_res = n_f;
            4'd7:  eval_res = v_f;
            4'd8:  eval_res = 1'b1;
            4'd9:  eval_res = ~z_f;
            4'd10: eval_res = ~(z_f | (n_f ^ v_f));
            4'd11: eval_res = ~(n_f ^ v_f);
            4'd12: eval_res = ~(c_f | z_f);
            4'd13: eval_res = ~c_f;
            4'd14: eval_res = ~n_f;
            4'd15: eval_res = ~v_f;
        endcase
    end

    always_comb begin
        psr_d        = psr_q;
        cond_true_d  = cond_true_q;
        cond_valid_d = cond_valid_q;
        if (flush) begin
            cond_true_d  = 1'b0;
            cond_valid_d = 1'b0;
        end else if (!stall) begin
            if (psr_upd) begin
                psr_d = alu_flags;
            end
            if (cond_req) begin
                cond_true_d  = eval_res;
                cond_valid_d = 1'b1;
            end else begin
                cond_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psr_q        <= 4'b0000;
            cond_true_q  <= 1'b0;
            cond_valid_q <= 1'b0;
        end else begin
            psr_q        <= psr_d;
            cond_true_q  <= cond_true_d;
            cond_valid_q <= cond_valid_d;
        end
    end

    // Cin deliberately taken from the committed PSR, never the bypass path.
    assign psr_flags  = psr_q;
    assign carry_in   = psr_q[1];
    assign cond_true  = cond_true_q;
    assign cond_valid = cond_valid_q;

endmodule

// File: tb/tb_flags_cond_unit.sv
// tb/tb_flags_cond_unit.sv - self-checking bench for flags_cond_unit
module tb_flags_cond_unit;

    logic       clk;
    logic       rst_n;
    logic [3:0] alu_flags;
    logic       ex_valid;
    logic       s_bit;
    logic [3:0] cond;
    logic       cond_req;
    logic       stall;
    logic       flush;
    logic [3:0] psr_flags;
    logic       carry_in;
    logic       cond_true;
    logic       cond_valid;

    int n_checks;
    int n_fail;
    logic sb_q[$];

    typedef struct {
        logic       ev;
        logic       s;
        logic [3:0] af;
        logic       cr;
        logic [3:0] cd;
        logic       st;
        logic       fl;
        logic [3:0] e_psr;
        logic       e_cv;
        logic       e_ct;
    } vec_t;

    vec_t vecs[$];

    flags_cond_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_flags  (alu_flags),
        .ex_valid   (ex_valid),
        .s_bit      (s_bit),
        .cond       (cond),
        .cond_req   (cond_req),
        .stall      (stall),
        .flush      (flush),
        .psr_flags  (psr_flags),
        .carry_in   (carry_in),
        .cond_true  (cond_true),
        .cond_valid (cond_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic ref_eval(input logic [3:0] c, input logic [3:0] f);
        logic z, n, cy, v, base;
        z  = f[3];
        n  = f[2];
        cy = f[1];
        v  = f[0];
        case (c[2:0])
            3'd0: base = 1'b0;
            3'd1: base = z;
            3'd2: base = z | (n ^ v);
            3'd3: base = n ^ v;
            3'd4: base = cy | z;
            3'd5: base = cy;
            3'd6: base = n;
            default: base = v;
        endcase
        return c[3] ? ~base : base;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input string name, input vec_t v);
        ex_valid  = v.ev;
        s_bit     = v.s;
        alu_flags = v.af;
        cond_req  = v.cr;
        cond      = v.cd;
        stall     = v.st;
        flush     = v.fl;
        if (v.e_cv) sb_q.push_back(v.e_ct);
        @(posedge clk);
        #1;
        chk({name, " psr"}, psr_flags, v.e_psr);
        chk({name, " carry_in"}, {3'b0, carry_in}, {3'b0, v.e_psr[1]});
        chk({name, " cond_valid"}, {3'b0, cond_valid}, {3'b0, v.e_cv});
        if (v.e_cv) begin
            if (sb_q.size() == 0) begin
                chk({name, " scoreboard empty"}, 4'd1, 4'd0);
            end else begin
                logic exp_ct;
                exp_ct = sb_q.pop_front();
                chk({name, " cond_true"}, {3'b0, cond_true}, {3'b0, exp_ct});
            end
        end else begin
            chk({name, " cond_true hold"}, {3'b0, cond_true}, {3'b0, v.e_ct});
        end
    endtask

    function automatic vec_t mk(input logic ev, input logic s, input logic [3:0] af,
                                input logic cr, input logic [3:0] cd, input logic st,
                                input logic fl, input logic [3:0] e_psr,
                                input logic e_cv, input logic e_ct);
        vec_t v;
        v.ev = ev; v.s = s; v.af = af; v.cr = cr; v.cd = cd; v.st = st; v.fl = fl;
        v.e_psr = e_psr; v.e_cv = e_cv; v.e_ct = e_ct;
        return v;
    endfunction

    initial begin
        logic last_ct;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        ex_valid  = 1'b0;
        s_bit     = 1'b0;
        alu_flags = 4'b0000;
        cond      = 4'd0;
        cond_req  = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;

        //              ev  s   af       cr  cd    st  fl  psr      cv  ct
        vecs.push_back(mk(0, 0, 4'b0000, 1, 4'd0,  0, 0, 4'b0000, 1, 0)); // never after reset
        vecs.push_back(mk(0, 0, 4'b0000, 1, 4'd8,  0, 0, 4'b0000, 1, 1)); // always
        vecs.push_back(mk(0, 0, 4'b0000, 0, 4'd8,  0, 0, 4'b0000, 0, 1)); // no req: ct holds
        vecs.push_back(mk(1, 1, 4'b1000, 1, 4'd1,  0, 0, 4'b1000, 1, 1)); // bypass Z
        vecs.push_back(mk(1, 1, 4'b0101, 1, 4'd11, 0, 0, 4'b0101, 1, 1)); // GE via bypass
        vecs.push_back(mk(0, 0, 4'b0000, 1, 4'd11, 0, 0, 4'b0101, 1, 1)); // GE from psr
        vecs.push_back(mk(1, 1, 4'b0100, 0, 4'd0,  0, 0, 4'b0100, 0, 1));
        vecs.push_back(mk(0, 0, 4'b0000, 1, 4'd3,  0, 0, 4'b0100, 1, 1)); // LT
        vecs.push_back(mk(0, 0, 4'b0000, 1, 4'd10, 0, 0, 4'b0100, 1, 0)); // GT
        vecs.push_back(mk(1, 1, 4'b0010, 0, 4'd0,  0, 0, 4'b0010, 0, 0));
        vecs.push_back(mk(1, 1, 4'b1000, 1, 4'd8,  1, 0, 4'b0010, 0, 0)); // stall holds
        vecs.push_back(mk(1, 1, 4'b1000, 1, 4'd8,  1, 0, 4'b0010, 0, 0));
        vecs.push_back(mk(1, 1, 4'b1000, 1, 4'd1,  0, 0, 4'b1000, 1, 1)); // release
        vecs.push_back(mk(0, 0, 4'b0000, 1, 4'd0,  1, 0, 4'b1000, 1, 1)); // stall holds valid
        vecs.push_back(mk(1, 1, 4'b0000, 1, 4'd8,  1, 1, 4'b1000, 0, 0)); // flush over stall
        vecs.push_back(mk(0, 0, 4'b0000, 1, 4'd8,  0, 0, 4'b1000, 1, 1));
        vecs.push_back(mk(1, 1, 4'b0001, 1, 4'd8,  0, 1, 4'b1000, 0, 0)); // flush alone
        vecs.push_back(mk(1, 1, 4'b0001, 0, 4'd0,  0, 0, 4'b0001, 0, 0)); // back-to-back writers
        vecs.push_back(mk(1, 1, 4'b0110, 0, 4'd0,  0, 0, 4'b0110, 0, 0));
        vecs.push_back(mk(1, 1, 4'b1001, 1, 4'd7,  0, 0, 4'b1001, 1, 1));
        vecs.push_back(mk(1, 1, 4'b1111, 1, 4'd8,  0, 0, 4'b1111, 1, 1)); // psr=1111 before reset

        #2;
        chk("reset psr", psr_flags, 4'b0000);
        chk("reset carry_in", {3'b0, carry_in}, 4'b0000);
        chk("reset cond_true", {3'b0, cond_true}, 4'b0000);
        chk("reset cond_valid", {3'b0, cond_valid}, 4'b0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // Async reset between edges, with an update and evaluation pending.
        ex_valid  = 1'b1;
        s_bit     = 1'b1;
        alu_flags = 4'b1010;
        cond_req  = 1'b1;
        cond      = 4'd8;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset psr", psr_flags, 4'b0000);
        chk("async reset carry_in", {3'b0, carry_in}, 4'b0000);
        chk("async reset cond_valid", {3'b0, cond_valid}, 4'b0000);
        chk("async reset cond_true", {3'b0, cond_true}, 4'b0000);
        @(posedge clk);
        #1;
        chk("in reset psr", psr_flags, 4'b0000);
        chk("in reset cond_valid", {3'b0, cond_valid}, 4'b0000);
        rst_n = 1'b1;
        step("post reset", mk(1, 1, 4'b0011, 1, 4'd13, 0, 0, 4'b0011, 1, 0));
        last_ct = 1'b0;

        for (int p = 0; p < 16; p++) begin
            for (int c = 0; c < 16; c++) begin
                logic r;
                step($sformatf("load psr=%0d", p), mk(1, 1, p[3:0], 0, 4'd0, 0, 0, p[3:0], 0, last_ct));
                r = ref_eval(c[3:0], p[3:0]);
                step($sformatf("sweep psr=%0d cond=%0d", p, c), mk(0, 0, 4'b0000, 1, c[3:0], 0, 0, p[3:0], 1, r));
                last_ct = r;
            end
        end

        chk("scoreboard drained", sb_q.size() == 0 ? 4'd0 : 4'd1, 4'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
